led_pwm_output: RTL and testbench

LED_PWM_OUTPUT -- requirements
Module: led_pwm_output

---
 rtl/led_pwm_output.sv | 116 +++++++++++
 tb/tb_led_pwm_output.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_output.sv
// led_pwm_output: register-mapped 4-channel LED PWM dimmer; blink logic built only with LED_PWM_BLINK_EN
module led_pwm_output (
    input  logic        CLK_mips,
    input  logic        RST_n,
    input  logic        WE,
    input  logic [1:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic [3:0]  LED_in,
    output logic [3:0]  LED_out
);
    logic        r_enable;
    logic [15:0] r_duty;
    logic [7:0]  r_prescale;
    logic [7:0]  r_pre_cnt;
    logic [3:0]  r_pwm_cnt;
    logic [3:0]  r_led_out;
    logic [3:0]  w_blink_mask;
    logic        w_blink_phase;
    logic        w_tick;
    logic        w_wr_ctrl;
    logic        w_wr_duty;
    logic        w_wr_pre;
    logic [3:0]  w_on;
    logic [3:0]  w_led_next;
    logic        w_unused;

    assign w_unused  = ^write_data[31:16];
    assign w_wr_ctrl = WE && addr == 2'd0;
    assign w_wr_duty = WE && addr == 2'd1;
    assign w_wr_pre  = WE && addr == 2'd2;
    assign w_tick    = r_pre_cnt == r_prescale;

`ifdef LED_PWM_BLINK_EN
    logic [3:0] r_blink_mask;
    logic [4:0] r_blink_cnt;

    // blink mask register and blink counter advancing once per PWM period
    always_ff @(posedge CLK_mips or negedge RST_n) begin
        if (!RST_n) begin
            r_blink_mask <= '0;
            r_blink_cnt  <= '0;
        end else begin
            if (w_wr_ctrl)
                r_blink_mask <= write_data[7:4];
            if (w_wr_pre)
                r_blink_cnt <= '0;
            else if (w_tick && r_pwm_cnt == 4'hF)
                r_blink_cnt <= r_blink_cnt + 5'd1;
        end
    end

    assign w_blink_mask  = r_blink_mask;
    assign w_blink_phase = r_blink_cnt[4];
`else
    assign w_blink_mask  = '0;
    assign w_blink_phase = 1'b0;
`endif

    // configuration registers; STATUS writes fall through untouched
    always_ff @(posedge CLK_mips or negedge RST_n) begin
        if (!RST_n) begin
            r_enable   <= 1'b0;
            r_duty     <= 16'hFFFF;
            r_prescale <= '0;
        end else begin
            if (w_wr_ctrl)
                r_enable <= write_data[0];
            if (w_wr_duty)
                r_duty <= write_data[15:0];
            if (w_wr_pre)
                r_prescale <= write_data[7:0];
        end
    end

    // prescaler and PWM counters; a PRESCALE write restarts them and beats a pending tick
    always_ff @(posedge CLK_mips or negedge RST_n) begin
        if (!RST_n) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else if (w_wr_pre) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pre_cnt <= w_tick ? 8'd0 : r_pre_cnt + 8'd1;
            r_pwm_cnt <= w_tick ? r_pwm_cnt + 4'd1 : r_pwm_cnt;
        end
    end

    // per-channel PWM compare; duty 15 is full on, duty 0 never on
    always_comb begin
        w_on = '0;
        for (int i = 0; i < 4; i++)
            w_on[i] = (r_duty[4*i +: 4] == 4'hF) || (r_pwm_cnt < r_duty[4*i +: 4]);
    end

    assign w_led_next = r_enable ? (LED_in & w_on & ~(w_blink_mask & {4{w_blink_phase}})) : LED_in;

    // LED pin drive register, one cycle behind its inputs
    always_ff @(posedge CLK_mips or negedge RST_n) begin
        if (!RST_n)
            r_led_out <= '0;
        else
            r_led_out <= w_led_next;
    end

    assign LED_out = r_led_out;

    // combinational register read mux
    always_comb begin
        read_data = addr == 2'd0 ? {24'h0, w_blink_mask, 3'b000, r_enable} :
                    addr == 2'd1 ? {16'h0, r_duty} :
                    addr == 2'd2 ? {24'h0, r_prescale} :
                                   {23'h0, w_blink_phase, 4'h0, r_pwm_cnt};
    end
endmodule

// File: tb/tb_led_pwm_output.sv
// tb_led_pwm_output: directed self-checking bench for led_pwm_output (blink checks follow LED_PWM_BLINK_EN)
module tb_led_pwm_output;
    logic        CLK_mips;
    logic        RST_n;
    logic        WE;
    logic [1:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [3:0]  LED_in;
    logic [3:0]  LED_out;
    int          vecs;
    int          errs;

    led_pwm_output dut (
        .CLK_mips   (CLK_mips),
        .RST_n      (RST_n),
        .WE         (WE),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .LED_in     (LED_in),
        .LED_out    (LED_out)
    );

    initial begin
        CLK_mips = 1'b0;
        forever #5 CLK_mips = ~CLK_mips;
    end

    task automatic tick1();
        @(posedge CLK_mips);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        WE = 1'b1;
        addr = a;
        write_data = d;
        tick1();
        WE = 1'b0;
        write_data = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = read_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        tick1();
        vecs++;
        if (LED_out !== 4'h0) begin errs++; $display("FAIL reset_led got %h want 0", LED_out); end
        rd(2'd0, v);
        vecs++;
        if (v !== 32'h0) begin errs++; $display("FAIL reset_ctrl got %h want 00000000", v); end
        rd(2'd1, v);
        vecs++;
        if (v !== 32'h0000FFFF) begin errs++; $display("FAIL reset_duty got %h want 0000ffff", v); end
        rd(2'd2, v);
        vecs++;
        if (v !== 32'h0) begin errs++; $display("FAIL reset_prescale got %h want 00000000", v); end
        rd(2'd3, v);
        vecs++;
        if (v !== 32'h0) begin errs++; $display("FAIL reset_status got %h want 00000000", v); end
        @(negedge CLK_mips);
        RST_n = 1'b1;
        LED_in = 4'b1010;
        tick1();
        vecs++;
        if (LED_out !== 4'b1010) begin errs++; $display("FAIL reset_passthru got %b want 1010", LED_out); end
    endtask

    task automatic test_pwm();
        logic [31:0] v;
        int c0, c1, c2, c3;
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        wr(2'd2, 32'd0);
        wr(2'd1, 32'h0F84);
        rd(2'd3, v);
        vecs++;
        if (v !== 32'd1) begin errs++; $display("FAIL duty_wr_keeps_cnt got %h want 1", v); end
        wr(2'd0, 32'h1);
        LED_in = 4'hF;
        rd(2'd3, v);
        vecs++;
        if (v !== 32'd2) begin errs++; $display("FAIL ctrl_wr_keeps_cnt got %h want 2", v); end
        for (int k = 0; k < 16; k++) begin
            tick1();
            c0 += int'(LED_out[0]);
            c1 += int'(LED_out[1]);
            c2 += int'(LED_out[2]);
            c3 += int'(LED_out[3]);
        end
        vecs++;
        if (c0 != 4) begin errs++; $display("FAIL pwm_led0_on got %0d want 4", c0); end
        vecs++;
        if (c1 != 8) begin errs++; $display("FAIL pwm_led1_on got %0d want 8", c1); end
        vecs++;
        if (c2 != 16) begin errs++; $display("FAIL pwm_led2_on got %0d want 16", c2); end
        vecs++;
        if (c3 != 0) begin errs++; $display("FAIL pwm_led3_on got %0d want 0", c3); end
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        logic [3:0] exp_seq [9];
        exp_seq = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
        wr(2'd2, 32'd3);
        rd(2'd2, v);
        vecs++;
        if (v !== 32'd3) begin errs++; $display("FAIL prescale_rd got %h want 3", v); end
        for (int k = 0; k < 9; k++) begin
            rd(2'd3, v);
            vecs++;
            if (v !== {28'h0, exp_seq[k]}) begin errs++; $display("FAIL prescale_seq[%0d] got %h want %h", k, v, exp_seq[k]); end
            if (k < 8) tick1();
        end
    endtask

    task automatic test_write_priority();
        logic [31:0] v;
        wr(2'd2, 32'd3);
        repeat (7) tick1();
        rd(2'd3, v);
        vecs++;
        if (v !== 32'd1) begin errs++; $display("FAIL prio_pre got %h want 1", v); end
        wr(2'd2, 32'd3);
        rd(2'd3, v);
        vecs++;
        if (v !== 32'd0) begin errs++; $display("FAIL prio_clear got %h want 0", v); end
        repeat (3) tick1();
        rd(2'd3, v);
        vecs++;
        if (v !== 32'd0) begin errs++; $display("FAIL prio_hold got %h want 0", v); end
        tick1();
        rd(2'd3, v);
        vecs++;
        if (v !== 32'd1) begin errs++; $display("FAIL prio_next got %h want 1", v); end
    endtask

    task automatic test_disable();
        logic [31:0] v1, v2;
        int bad;
        bad = 0;
        wr(2'd2, 32'd0);
        wr(2'd1, 32'h0F84);
        wr(2'd0, 32'h1);
        LED_in = 4'hF;
        wr(2'd0, 32'h0);
        LED_in = 4'b0101;
        tick1();
        vecs++;
        if (LED_out !== 4'b0101) begin errs++; $display("FAIL disable_pass got %b want 0101", LED_out); end
        for (int k = 0; k < 16; k++) begin
            tick1();
            if (LED_out !== 4'b0101) bad++;
        end
        vecs++;
        if (bad != 0) begin errs++; $display("FAIL disable_hold got %0d bad cycles want 0", bad); end
        rd(2'd3, v1);
        tick1();
        rd(2'd3, v2);
        vecs++;
        if (v2[3:0] !== v1[3:0] + 4'd1) begin errs++; $display("FAIL disable_cnt_runs got %h want %h", v2[3:0], v1[3:0] + 4'd1); end
    endtask

    task automatic test_blink();
        logic [31:0] v;
        int bad;
        bad = 0;
        wr(2'd2, 32'd0);
        wr(2'd1, 32'hFFFF);
        LED_in = 4'hF;
        wr(2'd0, 32'h11);
`ifdef LED_PWM_BLINK_EN
        rd(2'd0, v);
        vecs++;
        if (v !== 32'h11) begin errs++; $display("FAIL blink_ctrl_rd got %h want 11", v); end
        for (int n = 3; n <= 600; n++) begin
            tick1();
            if (LED_out !== ((n >= 257 && n <= 512) ? 4'b1110 : 4'b1111)) bad++;
            if (n == 255) begin
                rd(2'd3, v);
                vecs++;
                if (v[8] !== 1'b0) begin errs++; $display("FAIL blink_phase_255 got %b want 0", v[8]); end
            end
            if (n == 256) begin
                rd(2'd3, v);
                vecs++;
                if (v[8] !== 1'b1) begin errs++; $display("FAIL blink_phase_256 got %b want 1", v[8]); end
                vecs++;
                if (LED_out !== 4'hF) begin errs++; $display("FAIL blink_led_256 got %b want 1111", LED_out); end
            end
            if (n == 257) begin
                vecs++;
                if (LED_out !== 4'b1110) begin errs++; $display("FAIL blink_led_257 got %b want 1110", LED_out); end
            end
            if (n == 513) begin
                vecs++;
                if (LED_out !== 4'hF) begin errs++; $display("FAIL blink_led_513 got %b want 1111", LED_out); end
            end
        end
        vecs++;
        if (bad != 0) begin errs++; $display("FAIL blink_pattern got %0d bad cycles want 0", bad); end
`else
        rd(2'd0, v);
        vecs++;
        if (v !== 32'h01) begin errs++; $display("FAIL noblink_ctrl_rd got %h want 1", v); end
        for (int n = 3; n <= 600; n++) begin
            tick1();
            if (LED_out !== 4'hF) bad++;
            rd(2'd3, v);
            if (v[8] !== 1'b0) bad++;
        end
        vecs++;
        if (bad != 0) begin errs++; $display("FAIL noblink_steady got %0d bad cycles want 0", bad); end
`endif
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h0);
        LED_in = 4'hF;
        repeat (5) tick1();
        vecs++;
        if (LED_out !== 4'hF) begin errs++; $display("FAIL areset_pre got %b want 1111", LED_out); end
        #2;
        RST_n = 1'b0;
        #1;
        vecs++;
        if (LED_out !== 4'h0) begin errs++; $display("FAIL areset_led got %b want 0000", LED_out); end
        rd(2'd3, v);
        vecs++;
        if (v !== 32'h0) begin errs++; $display("FAIL areset_status got %h want 0", v); end
        rd(2'd1, v);
        vecs++;
        if (v !== 32'h0000FFFF) begin errs++; $display("FAIL areset_duty got %h want 0000ffff", v); end
        @(negedge CLK_mips);
        RST_n = 1'b1;
        LED_in = 4'b1010;
        rd(2'd3, v);
        vecs++;
        if (v !== 32'h0) begin errs++; $display("FAIL areset_cnt_release got %h want 0", v); end
        tick1();
        vecs++;
        if (LED_out !== 4'b1010) begin errs++; $display("FAIL areset_first_edge got %b want 1010", LED_out); end
        rd(2'd2, v);
        vecs++;
        if (v !== 32'h0) begin errs++; $display("FAIL areset_prescale got %h want 0", v); end
    endtask

    initial begin
        RST_n = 1'b0;
        WE = 1'b0;
        addr = 2'd0;
        write_data = '0;
        LED_in = 4'h0;
        vecs = 0;
        errs = 0;
        test_reset();
        test_pwm();
        test_prescale();
        test_write_priority();
        test_disable();
        test_blink();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
